int2fp_pipe: RTL and testbench

Parametrised, fully pipelined integer/fixed-point to IEEE-754 single-precision converter with valid/ready handshakes and a pass-through tag. It replaces banks of replicated single-shot converters in the preMCfilter datapath: one instance sustains one conversion per clock, and the tag carries channel identity so multiple logical channels share one unit. Added over the previous generation: parameter width, fixed-point scaling, per-sample signed/unsigned mode, round-to-nearest-even, and backpressure.

---
 rtl/int2fp_pkg.sv | 10 +
 rtl/int2fp_lzc.sv | 21 ++
 rtl/int2fp_pipe.sv | 111 +++++++++++
 tb/tb_int2fp_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/int2fp_pkg.sv
// rtl/int2fp_pkg.sv - FP32 encoding constants shared by the int2fp converter
package int2fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

endpackage

// File: rtl/int2fp_lzc.sv
// rtl/int2fp_lzc.sv - combinational leading-zero counter
// An all-zero input reports W.
module int2fp_lzc #(
    parameter int W = 32,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  i_data,
    output logic [CW-1:0] o_count
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        o_count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/int2fp_pipe.sv
// rtl/int2fp_pipe.sv - three-stage integer/fixed-point to FP32 converter
// Stages: sign/abs, normalise, round-to-nearest-even and pack.
module int2fp_pipe
    import int2fp_pkg::*;
#(
    parameter int INT_W     = 32,
    parameter int FRAC_BITS = 0,
    parameter int TAG_W     = 2
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_aresetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_data,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LZ_W     = $clog2(INT_W + 1);
    localparam int EXP_BASE = INT_W - 1 + BIAS - FRAC_BITS;
    localparam int EXT_W    = INT_W + MANT_W;

    logic             r_v1, r_v2, r_v3;
    logic             r_sign1, r_sign2;
    logic [INT_W-1:0] r_mag1;
    logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
    logic [INT_W-2:0] r_norm2;
    logic [EXP_W-1:0] r_exp2;
    logic             r_zero2;
    logic [31:0]      r_data3;

    logic             w_load1, w_load2, w_load3;
    logic             w_sign;
    logic [INT_W-1:0] w_mag;
    logic [LZ_W-1:0]  w_lz;
    logic [INT_W-1:0] w_norm;
    logic [EXT_W-1:0] w_ext;
    logic [MANT_W-1:0] w_mant;
    logic             w_guard, w_sticky, w_round;
    logic [MANT_W:0]  w_mant_r;
    logic [EXP_W-1:0] w_exp_r;
    logic [31:0]      w_result;

    // A stage may load when empty or when its contents move on this cycle.
    assign w_load3  = !r_v3 || out_ready;
    assign w_load2  = !r_v2 || w_load3;
    assign w_load1  = !r_v1 || w_load2;
    assign in_ready = w_load1;

    assign w_sign = in_signed & in_data[INT_W-1];
    assign w_mag  = w_sign ? -in_data : in_data;

    int2fp_lzc #(.W(INT_W)) u_lzc (
        .i_data  (r_mag1),
        .o_count (w_lz)
    );

    assign w_norm = r_mag1 << w_lz;

    // Zero padding below the fraction covers INT_W < 24 and leaves room for guard/sticky.
    assign w_ext    = {r_norm2, {(MANT_W + 1){1'b0}}};
    assign w_mant   = w_ext[EXT_W-1 -: MANT_W];
    assign w_guard  = w_ext[EXT_W-1-MANT_W];
    assign w_sticky = |w_ext[EXT_W-2-MANT_W:0];
    assign w_round  = w_guard && (w_sticky || w_mant[0]);
    assign w_mant_r = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_round};
    assign w_exp_r  = r_exp2 + {{(EXP_W-1){1'b0}}, w_mant_r[MANT_W]};
    assign w_result = r_zero2 ? FP32_ZERO : {r_sign2, w_exp_r, w_mant_r[MANT_W-1:0]};

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_data3 <= FP32_ZERO;
            r_tag3  <= '0;
        end else begin
            if (w_load1) r_v1 <= in_valid;
            if (w_load2) r_v2 <= r_v1;
            if (w_load3) r_v3 <= r_v2;
            if (w_load3 && r_v2) begin
                r_data3 <= w_result;
                r_tag3  <= r_tag2;
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (w_load1 && in_valid) begin
            r_sign1 <= w_sign;
            r_mag1  <= w_mag;
            r_tag1  <= in_tag;
        end
        if (w_load2 && r_v1) begin
            r_sign2 <= r_sign1;
            r_norm2 <= w_norm[INT_W-2:0];
            r_zero2 <= ~w_norm[INT_W-1];
            r_exp2  <= EXP_W'(EXP_BASE) - EXP_W'(w_lz);
            r_tag2  <= r_tag1;
        end
    end

    assign out_valid = r_v3;
    assign out_data  = r_data3;
    assign out_tag   = r_tag3;

endmodule

// File: tb/tb_int2fp_pipe.sv
// tb/tb_int2fp_pipe.sv - directed vector bench for int2fp_pipe
module tb_int2fp_pipe;

    typedef struct {
        logic [31:0] data;
        logic        sgn;
        logic [1:0]  tag;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  tag;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic [1:0]  in_tag = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_tag;

    logic        f_in_valid = 1'b0, f_in_signed = 1'b0, f_out_ready = 1'b1;
    logic [31:0] f_in_data = '0;
    logic [1:0]  f_in_tag = '0;
    logic        f_in_ready, f_out_valid;
    logic [31:0] f_out_data;
    logic [1:0]  f_out_tag;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    bit          chk_lat = 1'b1;
    logic [31:0] cur_exp = '0;
    exp_t        q[$];
    vec_t        vecs[11];

    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [1:0]  prev_tag = '0;

    always #5 clk = ~clk;

    int2fp_pipe #(.INT_W(32), .FRAC_BITS(0), .TAG_W(2)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_signed     (in_signed),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_tag       (out_tag)
    );

    int2fp_pipe #(.INT_W(32), .FRAC_BITS(16), .TAG_W(2)) dut_q16 (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .in_valid      (f_in_valid),
        .in_ready      (f_in_ready),
        .in_data       (f_in_data),
        .in_signed     (f_in_signed),
        .in_tag        (f_in_tag),
        .out_valid     (f_out_valid),
        .out_ready     (f_out_ready),
        .out_data      (f_out_data),
        .out_tag       (f_out_tag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1:       out_ready = ($urandom_range(0, 2) == 0);
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Scoreboard: handshakes seen here take effect at the following rising edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, prev_data);
                chk("stall_tag", 32'(out_tag), 32'(prev_tag));
            end
            chk("in_ready", 32'(in_ready), 32'(!(q.size() == 3 && !out_ready)));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("stale_output", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_tag", 32'(out_tag), 32'(e.tag));
                    if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd3);
                end
            end
            if (in_valid && in_ready) begin
                e.data = cur_exp;
                e.tag  = in_tag;
                e.cyc  = cyc;
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end
    end

    task automatic send(input logic [31:0] d, input logic s, input logic [1:0] t, input logic [31:0] e);
        bit acc;
        int n;
        in_data = d; in_signed = s; in_tag = t; cur_exp = e; in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0001, 1'b1, 2'd0, 32'h3F80_0000};
        vecs[1]  = '{32'hFFFF_FFFF, 1'b1, 2'd1, 32'hBF80_0000};
        vecs[2]  = '{32'h0000_0000, 1'b1, 2'd2, 32'h0000_0000};
        vecs[3]  = '{32'h8000_0000, 1'b1, 2'd3, 32'hCF00_0000};
        vecs[4]  = '{32'hFFFF_FFFF, 1'b0, 2'd0, 32'h4F80_0000};
        vecs[5]  = '{32'd16777217,  1'b0, 2'd1, 32'h4B80_0000};
        vecs[6]  = '{32'd16777219,  1'b0, 2'd2, 32'h4B80_0002};
        vecs[7]  = '{32'd16777218,  1'b0, 2'd3, 32'h4B80_0001};
        vecs[8]  = '{32'h7FFF_FFFF, 1'b1, 2'd0, 32'h4F00_0000};
        vecs[9]  = '{32'h8000_0000, 1'b0, 2'd1, 32'h4F00_0000};
        vecs[10] = '{32'h0000_0000, 1'b0, 2'd2, 32'h0000_0000};

        #1 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_out_tag", 32'(out_tag), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        foreach (vecs[i]) send(vecs[i].data, vecs[i].sgn, vecs[i].tag, vecs[i].exp);
        wait_drain();

        chk_lat  = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send(32'd1 << i, 1'b0, 2'(i), 32'(127 + i) << 23);
        wait_drain();
        rdy_mode = 0;
        chk_lat  = 1'b1;
        @(posedge clk);
        #2;

        f_in_data = 32'h0001_8000; f_in_signed = 1'b0; f_in_tag = 2'd1; f_in_valid = 1'b1;
        chk("q16_in_ready", 32'(f_in_ready), 32'd1);
        @(posedge clk);
        #2 f_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("q16_valid_a", 32'(f_out_valid), 32'd1);
        chk("q16_data_a", f_out_data, 32'h3FC0_0000);
        chk("q16_tag_a", 32'(f_out_tag), 32'd1);
        @(posedge clk);
        #2;
        f_in_data = 32'hFFFF_0000; f_in_signed = 1'b1; f_in_tag = 2'd2; f_in_valid = 1'b1;
        @(posedge clk);
        #2 f_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("q16_valid_b", 32'(f_out_valid), 32'd1);
        chk("q16_data_b", f_out_data, 32'hBF80_0000);
        chk("q16_tag_b", 32'(f_out_tag), 32'd2);
        @(posedge clk);
        #2;

        rdy_mode = 2;
        @(posedge clk);
        #2;
        send(32'd5, 1'b0, 2'd1, 32'h40A0_0000);
        send(32'd6, 1'b0, 2'd2, 32'h40C0_0000);
        send(32'd7, 1'b0, 2'd3, 32'h40E0_0000);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", out_data, 32'h0);
        chk("async_rst_tag", 32'(out_tag), 32'd0);
        q.delete();
        rdy_mode = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        send(32'd2, 1'b0, 2'd2, 32'h4000_0000);
        wait_drain();
        repeat (5) @(posedge clk);
        #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
